// File: rtl/theta_slice_pkg.sv
// Shared definitions for the theta / rotate / later permutation stages.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package theta_slice_pkg;

  localparam int SLICE_W = 25;  // bits per slice, bit i -> x = i % 5, y = i / 5
  localparam int DEPTH   = 64;  // slices per state (lane length)
  localparam int Z_W     = 6;   // slice index / counter width
  localparam int COLS    = 5;
  localparam int ROWS    = 5;

  localparam logic [Z_W-1:0] Z_LAST = Z_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } theta_state_t;

  // Bit position of lane (x, y) inside a slice.
  function automatic int xy_bit(input int x, input int y);
    return x + COLS * y;
  endfunction

endpackage

// File: rtl/theta_slice_if.sv
// Slice stream bundle for theta_slice: frame control, load side, emit side, status.
// Latency: n/a (wires only).
// Backpressure: in_ready stalls the loader, out_ready stalls the emitter.
// master = the surrounding logic driving start/in_*/out_ready; slave = theta_slice.
interface theta_slice_if;
  import theta_slice_pkg::*;

  logic               start;
  logic               in_valid;
  logic [SLICE_W-1:0] in_slice;
  logic               in_ready;
  logic               out_valid;
  logic [SLICE_W-1:0] out_slice;
  logic [Z_W-1:0]     out_z;
  logic               out_ready;
  logic               busy;
  logic               done;

  modport master (
    output start, in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice, out_z, busy, done
  );

  modport slave (
    input  start, in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice, out_z, busy, done
  );

endinterface

// File: rtl/theta_slice_parity.sv
// Column parity of one slice: par[x] = XOR over y of slice[x + 5y].
// Latency: combinational.
// Backpressure: none.
// Ports: slice (25-bit input slice), par (5-bit column parity).
module theta_parity
  import theta_slice_pkg::*;
(
  input  logic [SLICE_W-1:0] slice,
  output logic [COLS-1:0]    par
);

  always_comb begin
    par = '0;
    for (int x = 0; x < COLS; x++) begin
      for (int y = 0; y < ROWS; y++) begin
        par[x] = par[x] ^ slice[xy_bit(x, y)];
      end
    end
  end

endmodule

// File: rtl/theta_slice.sv
// Theta mixing stage: buffers a 64-slice state, then emits each slice XORed with its column-parity correction, tagged with z.
// Latency: first output valid the cycle after slice 63 is accepted; then 1 slice/cycle while out_ready is high.
// Backpressure: in_ready high only in LOAD; out_slice/out_z/out_valid hold while out_ready is low.
// Ports: clk, rst (sync, active-high), io (theta_slice_if.slave: start, in_*, out_*, busy, done).
module theta_slice
  import theta_slice_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  theta_slice_if.slave  io
);

  theta_state_t state, state_nxt;

  logic [Z_W-1:0]     load_z;
  logic [SLICE_W-1:0] slice_mem [DEPTH];
  logic [COLS-1:0]    par_mem   [DEPTH];
  logic [COLS-1:0]    in_par;

  logic               out_valid_q;
  logic [SLICE_W-1:0] out_slice_q;
  logic [Z_W-1:0]     out_z_q;

  logic               load_fire, load_last, emit_fire, emit_last;
  logic [Z_W-1:0]     mix_z, mix_z_prev;
  logic [COLS-1:0]    mix_par, mix_par_prev, mix_d;
  logic [SLICE_W-1:0] mix_slice;

  theta_parity u_parity (
    .slice (io.in_slice),
    .par   (in_par)
  );

  assign load_fire = (state == ST_LOAD) && io.in_valid;
  assign load_last = load_fire && (load_z == Z_LAST);
  assign emit_fire = out_valid_q && io.out_ready;
  assign emit_last = emit_fire && (out_z_q == Z_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (io.start) state_nxt = ST_LOAD;
      ST_LOAD: if (load_last) state_nxt = ST_EMIT;
      ST_EMIT: if (emit_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- load side ----------------
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) load_z <= '0;
    else if (load_fire)          load_z <= load_z + 1'b1;
  end

  // Buffers are not reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      slice_mem[load_z] <= io.in_slice;
      par_mem[load_z]   <= in_par;
    end
  end

  // ---------------- theta mix of the next slice to register ----------------
  // The z=0 output is registered on the same edge that stores slice 63, so its
  // z-1 parity comes straight from the parity unit instead of par_mem[63].
  always_comb begin
    mix_z        = load_last ? '0 : out_z_q + 1'b1;
    mix_z_prev   = mix_z - 1'b1;
    mix_par      = par_mem[mix_z];
    mix_par_prev = load_last ? in_par : par_mem[mix_z_prev];
    mix_d        = '0;
    mix_slice    = '0;
    for (int x = 0; x < COLS; x++) begin
      mix_d[x] = mix_par[(x + COLS - 1) % COLS] ^ mix_par_prev[(x + 1) % COLS];
    end
    for (int x = 0; x < COLS; x++) begin
      for (int y = 0; y < ROWS; y++) begin
        mix_slice[xy_bit(x, y)] = slice_mem[mix_z][xy_bit(x, y)] ^ mix_d[x];
      end
    end
  end

  // ---------------- emit side ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_slice_q <= '0;
      out_z_q     <= '0;
    end else if (load_last) begin
      out_valid_q <= 1'b1;
      out_slice_q <= mix_slice;
      out_z_q     <= '0;
    end else if (emit_fire) begin
      if (out_z_q == Z_LAST) begin
        out_valid_q <= 1'b0;
      end else begin
        out_slice_q <= mix_slice;
        out_z_q     <= mix_z;
      end
    end
  end

  assign io.in_ready  = (state == ST_LOAD);
  assign io.out_valid = out_valid_q;
  assign io.out_slice = out_slice_q;
  assign io.out_z     = out_z_q;
  assign io.busy      = (state != ST_IDLE);
  assign io.done      = (state == ST_DONE);

endmodule

// File: tb/tb_theta_slice.sv
// Self-checking bench for theta_slice: directed test-plan frames plus random frames against a behavioural theta model.
// Latency: n/a.
// Backpressure: random in_valid gaps and random out_ready stalls.
module tb_theta_slice;
  import theta_slice_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  theta_slice_if bus ();

  theta_slice dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [SLICE_W-1:0] frame [DEPTH];
  logic [SLICE_W-1:0] expv  [DEPTH];
  logic [SLICE_W-1:0] got   [DEPTH];

  bit r_timeout, r_done_ok, r_idle_ok;
  int r_order_err, r_stable_err, r_proto_err;

  // Reference: theta straight from its definition on the whole state.
  function automatic void build_expected();
    bit par [DEPTH][COLS];
    for (int z = 0; z < DEPTH; z++)
      for (int x = 0; x < COLS; x++) begin
        par[z][x] = 1'b0;
        for (int y = 0; y < ROWS; y++) par[z][x] = par[z][x] ^ frame[z][x + 5 * y];
      end
    for (int z = 0; z < DEPTH; z++)
      for (int i = 0; i < SLICE_W; i++)
        expv[z][i] = frame[z][i] ^ par[z][(i % 5 + 4) % 5] ^ par[(z + DEPTH - 1) % DEPTH][(i % 5 + 1) % 5];
  endfunction

  function automatic void clear_frame();
    for (int z = 0; z < DEPTH; z++) begin
      frame[z] = '0;
      expv[z]  = '0;
      got[z]   = '1;
    end
  endfunction

  function automatic void random_frame();
    for (int z = 0; z < DEPTH; z++) begin
      frame[z] = ($urandom_range(0, 1) == 0) ? SLICE_W'($urandom) : SLICE_W'(1) << $urandom_range(0, SLICE_W - 1);
      got[z]   = '1;
    end
    build_expected();
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_slice  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_frame(input int n, input bit gaps);
    int idx = 0;
    int cyc = 0;
    r_timeout = 0; r_order_err = 0; r_stable_err = 0; r_proto_err = 0;
    r_done_ok = 0; r_idle_ok = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    while (idx < n && cyc < 1000) begin
      if (bus.out_valid !== 1'b0) r_proto_err++;
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_slice = bus.in_valid ? frame[idx] : SLICE_W'($urandom);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1 cyc++;
    end
    bus.in_valid = 1'b0;
    if (idx < n) r_timeout = 1;
  endtask

  task automatic emit_frame(input int ready_pct, input bit poke_start);
    int cnt = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [SLICE_W-1:0] hold_s;
    logic [Z_W-1:0]     hold_z;
    while (cnt < DEPTH && cyc < 2000) begin
      if (bus.done !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) r_proto_err++;
      if (stalled && (bus.out_slice !== hold_s || bus.out_z !== hold_z)) r_stable_err++;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      bus.start     = poke_start && ($urandom_range(0, 7) == 0);
      bus.in_valid  = 1'b1;
      bus.in_slice  = SLICE_W'($urandom);
      stalled = 0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          if (int'(bus.out_z) != cnt) r_order_err++;
          got[cnt] = bus.out_slice;
          cnt++;
        end else begin
          stalled = 1;
          hold_s  = bus.out_slice;
          hold_z  = bus.out_z;
        end
      end
      @(posedge clk);
      #1 cyc++;
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    if (cnt < DEPTH) r_timeout = 1;
    r_done_ok = (bus.done === 1'b1 && bus.out_valid === 1'b0 && bus.busy === 1'b1);
    @(posedge clk);
    #1 r_idle_ok = (bus.done === 1'b0 && bus.busy === 1'b0 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0);
  endtask

  task automatic run_frame(input bit gaps, input int ready_pct, input bit poke_start);
    load_frame(DEPTH, gaps);
    emit_frame(ready_pct, poke_start);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.out_slice !== '0)   begin errors++; $display("FAIL reset_out_slice got %h exp 0", bus.out_slice); end
    checks++; if (bus.out_z !== '0)       begin errors++; $display("FAIL reset_out_z got %0d exp 0", bus.out_z); end
  endtask

  task automatic test_directed(input string name, input int gaps, input int ready_pct);
    run_frame(gaps != 0, ready_pct, 1'b0);
    checks++;
    if (r_timeout || r_order_err != 0 || r_stable_err != 0 || r_proto_err != 0 || !r_done_ok || !r_idle_ok) begin
      errors++;
      $display("FAIL %s_protocol timeout=%0d order=%0d stable=%0d proto=%0d done_ok=%0d idle_ok=%0d exp 0/0/0/0/1/1",
               name, r_timeout, r_order_err, r_stable_err, r_proto_err, r_done_ok, r_idle_ok);
    end
    for (int z = 0; z < DEPTH; z++) begin
      checks++;
      if (got[z] !== expv[z]) begin
        errors++;
        $display("FAIL %s_z%0d got %h exp %h", name, z, got[z], expv[z]);
      end
    end
  endtask

  task automatic test_all_zero();
    clear_frame();
    test_directed("all_zero", 0, 100);
  endtask

  task automatic test_single_bit();
    clear_frame();
    frame[0] = 25'h0000001;
    expv[0]  = 25'h0210843;
    expv[1]  = 25'h1084210;
    test_directed("single_bit", 0, 100);
  endtask

  task automatic test_z_wrap();
    clear_frame();
    frame[63] = 25'h0000001;
    expv[0]   = 25'h1084210;
    expv[63]  = 25'h0210843;
    test_directed("z_wrap", 0, 100);
  endtask

  task automatic test_even_parity();
    clear_frame();
    frame[5] = 25'h0000021;
    expv[5]  = 25'h0000021;
    test_directed("even_parity", 0, 100);
  endtask

  task automatic test_backpressure();
    clear_frame();
    frame[0] = 25'h0000001;
    expv[0]  = 25'h0210843;
    expv[1]  = 25'h1084210;
    test_directed("backpressure", 1, 45);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      random_frame();
      run_frame(1'b1, 60, 1'b1);
      checks++;
      if (r_timeout || r_order_err != 0 || r_stable_err != 0 || r_proto_err != 0 || !r_done_ok || !r_idle_ok) begin
        errors++;
        $display("FAIL random%0d_protocol timeout=%0d order=%0d stable=%0d proto=%0d done_ok=%0d idle_ok=%0d exp 0/0/0/0/1/1",
                 n, r_timeout, r_order_err, r_stable_err, r_proto_err, r_done_ok, r_idle_ok);
      end
      for (int z = 0; z < DEPTH; z++) begin
        checks++;
        if (got[z] !== expv[z]) begin
          errors++;
          $display("FAIL random%0d_z%0d got %h exp %h", n, z, got[z], expv[z]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int seen = 0;
    random_frame();
    load_frame(30, 1'b0);
    pulse_reset();
    checks++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL midload_in_ready got %b exp 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midload_busy got %b exp 0", bus.busy); end
    bus.out_ready = 1'b1;
    repeat (8) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL midload_quiet got %0d active cycles exp 0", seen); end
    random_frame();
    run_frame(1'b1, 70, 1'b0);
    checks++;
    if (r_timeout || r_order_err != 0 || r_proto_err != 0 || !r_done_ok) begin
      errors++;
      $display("FAIL midload_fresh_protocol timeout=%0d order=%0d proto=%0d done_ok=%0d", r_timeout, r_order_err, r_proto_err, r_done_ok);
    end
    for (int z = 0; z < DEPTH; z++) begin
      checks++;
      if (got[z] !== expv[z]) begin errors++; $display("FAIL midload_fresh_z%0d got %h exp %h", z, got[z], expv[z]); end
    end
  endtask

  task automatic test_reset_mid_emit();
    random_frame();
    load_frame(DEPTH, 1'b0);
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    pulse_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midemit_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midemit_busy got %b exp 0", bus.busy); end
    checks++; if (bus.out_z !== '0)       begin errors++; $display("FAIL midemit_out_z got %0d exp 0", bus.out_z); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_bit();
    test_z_wrap();
    test_even_parity();
    test_backpressure();
    test_random();
    test_reset_mid_load();
    test_reset_mid_emit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
